// File: rtl/regfile_wb_writer_pkg.sv
// Shared types for the register file writeback writer:
// data width, register address width, grant states and the writeback item.
package wb_pkg;
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        ALU_PRI,
        FORCE_LD
    } grant_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_item_t;
endpackage

// File: rtl/regfile_wb_writer_if.sv
// ALU request, load return and register file write port bundle.
// The master side drives the requests; the writer is the slave.
interface regfile_wb_writer_if
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;
    logic                  rf_rw;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_wd;
    logic [31:0]           pending_mask;
    logic [$clog2(DEPTH):0] fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        input  alu_ready, ld_ready,
        input  rf_rw, rf_rd, rf_wd,
        input  pending_mask, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        output alu_ready, ld_ready,
        output rf_rw, rf_rd, rf_wd,
        output pending_mask, fifo_count
    );
endinterface

// File: rtl/regfile_wb_writer_load_fifo.sv
// Circular load-return buffer; exposes per-entry rd/valid so the
// writer can build the pending-load mask.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  wb_item_t               push_item,
    input  logic                   pop,
    output wb_item_t               head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd,
    output logic [DEPTH-1:0]       ent_vld
);
    localparam int AW = $clog2(DEPTH);

    wb_item_t        mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     cnt;
    logic [DEPTH-1:0] vld;

    assign head    = mem[rptr];
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign ent_vld = vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign ent_rd[i] = mem[i].rd;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_item;
        end
    end

    // Push after pop so a full-FIFO slot reuse keeps its valid bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            vld  <= '0;
        end else begin
            if (pop) begin
                rptr      <= rptr + 1'b1;
                vld[rptr] <= 1'b0;
            end
            if (push) begin
                wptr      <= wptr + 1'b1;
                vld[wptr] <= 1'b1;
            end
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/regfile_wb_writer.sv
// Merges ALU results and buffered load returns onto the register file
// write port. Optional WB_BYPASS_EN lets a load skip an empty FIFO.
module regfile_wb_writer
    import wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3,
    parameter int XLEN       = wb_pkg::XLEN
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wb_writer_if.slave  wb
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    grant_state_t          state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_n;
    wb_item_t              head;
    wb_item_t              sel;
    wb_item_t              ld_item;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  alu_g;
    logic                  byp;
    logic                  grant;
    logic [$clog2(DEPTH):0] count;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;
    logic [DEPTH-1:0]      ent_vld;
    logic [31:0]           mask;
    logic                  rw_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       wd_q;

    assign ld_item.rd   = wb.ld_rd;
    assign ld_item.data = wb.ld_data;

    assign alu_g = (state == ALU_PRI) && wb.alu_valid;
    assign pop   = !empty && ((state == FORCE_LD) || !wb.alu_valid);

`ifdef WB_BYPASS_EN
    assign byp = empty && !wb.alu_valid && (state == ALU_PRI)
                 && wb.ld_valid;
`else
    assign byp = 1'b0;
`endif

    assign grant        = alu_g || pop || byp;
    assign wb.alu_ready = (state == ALU_PRI);
    assign wb.ld_ready  = !full || pop;
    assign push         = wb.ld_valid && wb.ld_ready && !byp;

    wb_load_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_item (ld_item),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .ent_rd    (ent_rd),
        .ent_vld   (ent_vld)
    );

    always_comb begin
        sel = ld_item;
        unique case (1'b1)
            alu_g: begin
                sel.rd   = wb.alu_rd;
                sel.data = wb.alu_data;
            end
            pop:     sel = head;
            default: sel = ld_item;
        endcase
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_rd[i] != '0)) begin
                mask[ent_rd[i]] = 1'b1;
            end
        end
    end

    // Counter only runs while ALU grants keep a non-empty FIFO waiting.
    always_comb begin
        cnt_n = cnt;
        if (pop || empty) begin
            cnt_n = '0;
        end else if (alu_g) begin
            cnt_n = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ALU_PRI;
            cnt   <= '0;
            rw_q  <= 1'b0;
            rd_q  <= '0;
            wd_q  <= '0;
        end else begin
            cnt <= cnt_n;
            if (state == FORCE_LD) begin
                state <= ALU_PRI;
            end else if (cnt_n == CW'(STARVE_MAX)) begin
                state <= FORCE_LD;
            end
            rw_q <= grant && (sel.rd != '0);
            if (grant) begin
                rd_q <= sel.rd;
                wd_q <= sel.data;
            end
        end
    end

    assign wb.rf_rw        = rw_q;
    assign wb.rf_rd        = rd_q;
    assign wb.rf_wd        = wd_q;
    assign wb.pending_mask = mask;
    assign wb.fifo_count   = count;
endmodule

// File: tb/tb_regfile_wb_writer.sv
// Randomised scoreboard bench for regfile_wb_writer with a queue-based
// reference model of the load FIFO, arbitration and write port.
module tb_regfile_wb_writer;
    import wb_pkg::*;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    regfile_wb_writer_if #(.DEPTH(DEPTH)) bus ();

    regfile_wb_writer #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    always #5 clk = ~clk;

    logic        av  = 1'b0;
    logic [4:0]  ard = '0;
    logic [63:0] ad  = '0;
    logic        lv  = 1'b0;
    logic [4:0]  lrd = '0;
    logic [63:0] ldd = '0;

    assign bus.alu_valid = av;
    assign bus.alu_rd    = ard;
    assign bus.alu_data  = ad;
    assign bus.ld_valid  = lv;
    assign bus.ld_rd     = lrd;
    assign bus.ld_data   = ldd;

    wb_item_t q[$];
    wb_item_t expq[$];
    int  checks  = 0;
    int  errors  = 0;
    int  scnt    = 0;
    bit  frc     = 1'b0;
    bit  alu_acc = 1'b1;
    bit  ld_acc  = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (q[i]) begin
            if (q[i].rd != 0) m[q[i].rd] = 1'b1;
        end
        return m;
    endfunction

    // One cycle of the reference model, evaluated with inputs settled.
    task automatic step();
        bit       empty;
        bit       ag;
        bit       pop;
        bit       lr;
        bit       byp;
        wb_item_t it;
        if (!reset) begin
            q.delete();
            expq.delete();
            scnt    = 0;
            frc     = 1'b0;
            alu_acc = 1'b1;
            ld_acc  = 1'b1;
            return;
        end
        chk("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
        chk("pending_mask", 64'(bus.pending_mask), 64'(model_mask()));
        empty = (q.size() == 0);
        byp   = 1'b0;
`ifdef WB_BYPASS_EN
        byp = empty && !av && !frc && lv;
`endif
        ag  = !frc && av;
        pop = !empty && (frc || !av);
        lr  = (q.size() < DEPTH) || pop;
        chk("alu_ready", 64'(bus.alu_ready), 64'(!frc));
        chk("ld_ready", 64'(bus.ld_ready), 64'(lr));
        if (ag) it = '{rd: ard, data: ad};
        else if (pop) it = q.pop_front();
        else it = '{rd: lrd, data: ldd};
        if ((ag || pop || byp) && it.rd != 0) expq.push_back(it);
        if (lv && lr && !byp) q.push_back('{rd: lrd, data: ldd});
        if (frc) begin
            frc  = 1'b0;
            scnt = 0;
        end else if (pop || empty) begin
            scnt = 0;
        end else if (ag) begin
            scnt++;
            frc = (scnt == STARVE_MAX);
        end
        alu_acc = ag;
        ld_acc  = lv && lr;
    endtask

    // New request values only replace ones already accepted or idle.
    task automatic put(input bit a_v, input logic [4:0] a_rd,
                       input logic [63:0] a_d, input bit l_v,
                       input logic [4:0] l_rd, input logic [63:0] l_d);
        @(negedge clk);
        reset = 1'b1;
        if (!av || alu_acc) begin
            av  = a_v;
            ard = a_rd;
            ad  = a_d;
        end
        if (!lv || ld_acc) begin
            lv  = l_v;
            lrd = l_rd;
            ldd = l_d;
        end
        #1 step();
    endtask

    task automatic cyc(input int pa, input int pl, input int rdmax);
        put(int'($urandom_range(99)) < pa,
            5'($urandom_range(rdmax)), {$urandom, $urandom},
            int'($urandom_range(99)) < pl,
            5'($urandom_range(rdmax)), {$urandom, $urandom});
    endtask

    task automatic rst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b0;
            av    = 1'b1;
            lv    = 1'b1;
            #1 step();
        end
    endtask

    initial begin : monitor
        bit       want;
        wb_item_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                chk("rst_rf_rw", 64'(bus.rf_rw), 64'(0));
                chk("rst_count", 64'(bus.fifo_count), 64'(0));
                chk("rst_mask", 64'(bus.pending_mask), 64'(0));
            end else begin
                want = (expq.size() != 0);
                chk("rf_rw", 64'(bus.rf_rw), 64'(want));
                if (want) begin
                    e = expq.pop_front();
                    if (bus.rf_rw) begin
                        chk("rf_rd", 64'(bus.rf_rd), 64'(e.rd));
                        chk("rf_wd", bus.rf_wd, e.data);
                    end
                end
            end
        end
    end

    initial begin : driver
        rst(2);
        put(1, 5'd5, 64'hA5, 0, 5'd0, 64'h0);
        put(1, 5'd0, 64'h77, 0, 5'd0, 64'h0);
        put(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
        put(0, 5'd0, 64'h0, 1, 5'd7, 64'h11);
        repeat (3) put(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
        put(1, 5'd1, 64'h100, 1, 5'd9, 64'h99);
        for (int i = 0; i < 8; i++) begin
            put(1, 5'(i + 2), 64'(i + 'h200), 0, 5'd0, 64'h0);
        end
        repeat (16) cyc(100, 100, 7);
        repeat (10) cyc(0, 0, 7);
        repeat (5) cyc(100, 100, 7);
        rst(2);
        repeat (400) cyc(60, 50, 7);
        repeat (300) cyc(85, 70, 3);
        repeat (10) cyc(0, 0, 7);
        put(0, 5'd0, 64'h0, 1, 5'd3, 64'h22);
        repeat (4) put(0, 5'd0, 64'h0, 0, 5'd0, 64'h0);
        @(negedge clk);
        chk("drain_exp", 64'(expq.size()), 64'(0));
        chk("drain_fifo", 64'(bus.fifo_count), 64'(q.size()));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
